// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional same-cycle bypass is selected by the IFQ_BYPASS_EN macro in inst_fetch_queue.
package ifq_pkg;

    typedef logic [1:0] ifq_state_t;

    localparam ifq_state_t StIdle = 2'd0;
    localparam ifq_state_t StReq  = 2'd1;
    localparam ifq_state_t StDrop = 2'd2;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNC_MSB   = 5;
    localparam int unsigned FUNC_LSB   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous prefetch FIFO of {pc, inst} entries with flush; Depth must be a power of two.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  ifq_entry_t      entry_i,
    input  logic            pop_i,
    output ifq_entry_t      head_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o,
    output logic            full_o
);

    ifq_entry_t            mem_q [Depth];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // Storage needs no reset; count_q gates every read.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: req/ack fetch from memory into a prefetch FIFO, valid/ready to decode.
// Define IFQ_BYPASS_EN to forward an ack straight to the output when the FIFO is empty.
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o,
    output logic [5:0]  out_opcode_o,
    output logic [5:0]  out_func_o
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    ifq_state_t      state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     drop_addr_q, drop_addr_d;

    ifq_entry_t      fifo_head, fifo_entry;
    logic [CntW-1:0] fifo_count, cnt_after;
    logic            fifo_empty, fifo_full;
    logic            take, push, pop, bypass_take;

    assign mem_req_o  = (state_q != StIdle);
    assign mem_addr_o = (state_q == StDrop) ? drop_addr_q : fetch_pc_q;

    // Accepted response: a live request acknowledged and not cancelled by a redirect.
    assign take       = (state_q == StReq) && mem_ack_i && !redirect_i;
    assign fifo_entry = '{pc: fetch_pc_q, inst: mem_rdata_i};

`ifdef IFQ_BYPASS_EN
    logic bypass_vld;
    assign bypass_vld  = take && fifo_empty;
    assign bypass_take = bypass_vld && out_ready_i;
    assign out_valid_o = !fifo_empty || bypass_vld;
    assign out_inst_o  = bypass_vld ? mem_rdata_i : fifo_head.inst;
    assign out_pc_o    = bypass_vld ? fetch_pc_q  : fifo_head.pc;
`else
    assign bypass_take = 1'b0;
    assign out_valid_o = !fifo_empty;
    assign out_inst_o  = fifo_head.inst;
    assign out_pc_o    = fifo_head.pc;
`endif

    assign out_opcode_o = out_inst_o[OPCODE_MSB:OPCODE_LSB];
    assign out_func_o   = out_inst_o[FUNC_MSB:FUNC_LSB];

    assign pop       = !fifo_empty && out_ready_i && !redirect_i;
    assign push      = take && !bypass_take;
    assign cnt_after = fifo_count + CntW'(push) - CntW'(pop);

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        if (redirect_i) fetch_pc_d = redirect_pc_i & ~32'h3;
        case (state_q)
            StIdle: begin
                if (!redirect_i && !fifo_full) state_d = StReq;
            end
            StReq: begin
                if (redirect_i) begin
                    // Without an ack the request stays on the bus and its data must be dropped.
                    state_d     = mem_ack_i ? StIdle : StDrop;
                    drop_addr_d = fetch_pc_q;
                end else if (mem_ack_i) begin
                    fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
                    state_d    = (cnt_after < CntW'(DEPTH)) ? StReq : StIdle;
                end
            end
            StDrop: begin
                if (mem_ack_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    ifq_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (push),
        .entry_i (fifo_entry),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against a queue-level model of the fetch stream.
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst, out_pc;
    logic [5:0]  out_opcode, out_func;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_inst_o    (out_inst),
        .out_pc_o      (out_pc),
        .out_opcode_o  (out_opcode),
        .out_func_o    (out_func)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: expected delivery order, expected fetch order, occupancy and pending-drop flag.
    int          qcount, acks, pops, cyc, first_valid, wait_cnt, lat, lat_mode;
    logic [31:0] exp_pc, fetch_exp, salt, prev_addr, prev_out_pc, prev_out_inst;
    logic [31:0] last_pop_pc;
    logic [5:0]  last_pop_op, last_pop_fn;
    bit          dropping, prev_hold, prev_out_hold, found;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] memfunc(input logic [31:0] a);
        if (a == 32'h8) return 32'h0000_0020;
        if (a == 32'hC) return 32'h2008_0005;
        return a ^ salt;
    endfunction

    task automatic apply_reset();
        #2;
        rst_n    = 1'b0;
        mem_ack  = 1'b0;
        redirect = 1'b0;
        #1;
        check_eq("rst_req", {31'b0, mem_req}, 32'h0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_valid", {31'b0, out_valid}, 32'h0);
        qcount = 0; acks = 0; pops = 0; wait_cnt = 0;
        lat = (lat_mode < 0) ? 0 : lat_mode;
        exp_pc = '0; fetch_exp = '0;
        dropping = 0; prev_hold = 0; prev_out_hold = 0; first_valid = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic cycle(input bit rd, input logic [31:0] rpc, input bit rdy);
        bit acc, fire, exp_valid, by_used;
        int q0;
        @(negedge clk);
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        if (mem_req && wait_cnt >= lat) begin
            mem_ack   = 1'b1;
            mem_rdata = memfunc(mem_addr);
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end
        #1;
        if (prev_hold) begin
            check_eq("req_hold", {31'b0, mem_req}, 32'h1);
            check_eq("addr_hold", mem_addr, prev_addr);
        end
        acc = mem_req && mem_ack && !rd && !dropping;
        q0  = qcount;
        exp_valid = (q0 > 0);
`ifdef IFQ_BYPASS_EN
        if (acc && q0 == 0) exp_valid = 1'b1;
`endif
        check_eq("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (prev_out_hold) begin
            check_eq("stall_pc", out_pc, prev_out_pc);
            check_eq("stall_inst", out_inst, prev_out_inst);
        end
        fire = out_valid && rdy && !rd;
        if (fire) begin
            check_eq("pop_pc", out_pc, exp_pc);
            check_eq("pop_inst", out_inst, memfunc(exp_pc));
            check_eq("pop_opcode", {26'b0, out_opcode}, {26'b0, memfunc(exp_pc) >> 26});
            check_eq("pop_func", {26'b0, out_func}, {26'b0, memfunc(exp_pc) & 32'h3F});
            last_pop_pc = out_pc; last_pop_op = out_opcode; last_pop_fn = out_func;
            exp_pc += 4;
            pops++;
        end
        if (acc) begin
            check_eq("fetch_addr", mem_addr, fetch_exp);
            fetch_exp += 4;
            acks++;
        end
        if (rd) begin
            qcount    = 0;
            exp_pc    = rpc & ~32'h3;
            fetch_exp = rpc & ~32'h3;
        end else begin
            by_used = fire && q0 == 0;
            qcount  = q0 - ((fire && q0 > 0) ? 1 : 0) + ((acc && !by_used) ? 1 : 0);
            if (acc) check_eq("no_overflow", {31'b0, qcount <= DEPTH}, 32'h1);
        end
        if (mem_req && mem_ack) dropping = 0;
        else if (rd && mem_req) dropping = 1;
        if (mem_req && mem_ack) begin
            wait_cnt = 0;
            lat = (lat_mode < 0) ? $urandom_range(0, 3) : lat_mode;
        end else if (mem_req) begin
            wait_cnt++;
        end
        prev_hold     = mem_req && !mem_ack;
        prev_addr     = mem_addr;
        prev_out_hold = out_valid && !rdy && !rd;
        prev_out_pc   = out_pc;
        prev_out_inst = out_inst;
        cyc++;
    endtask

    initial begin
        int p0;
        salt = '0;
        lat_mode = 0;
        apply_reset();

        // First delivery latency and streaming at one per cycle.
        repeat (8) cycle(0, '0, 1);
`ifdef IFQ_BYPASS_EN
        check_eq("first_valid_cyc", 32'(first_valid), 32'd0);
`else
        check_eq("first_valid_cyc", 32'(first_valid), 32'd1);
`endif
        check_eq("stream_pops", 32'(pops), 32'(acks - qcount));

        // Back-pressure fills the FIFO and fetching stops.
        apply_reset();
        repeat (10) cycle(0, '0, 0);
        check_eq("fill_acks", 32'(acks), DEPTH);
        check_eq("fill_req_off", {31'b0, mem_req}, 32'h0);
        check_eq("fill_head_pc", out_pc, 32'h0);

        // Resume toward 0x10 with a slow response, then redirect while it is pending.
        lat_mode = 6; lat = 6;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle(0, '0, 1);
            if (mem_req && !mem_ack && mem_addr == 32'h10) found = 1;
        end
        check_eq("resume_addr_0x10", {31'b0, found}, 32'h1);
        lat_mode = 0;
        cycle(1, 32'h400, 1);
        p0 = pops;
        for (int i = 0; i < 40 && pops == p0; i++) cycle(0, '0, 1);
        check_eq("redir_first_pc", last_pop_pc, 32'h400);

        // Redirect with ack and pop in the same cycle.
        apply_reset();
        repeat (6) cycle(0, '0, 1);
        cycle(1, 32'h203, 1);
        check_eq("rd_same_ack", {31'b0, mem_ack}, 32'h1);
`ifdef IFQ_BYPASS_EN
        check_eq("rd_same_valid", {31'b0, out_valid}, 32'h0);
`else
        check_eq("rd_same_valid", {31'b0, out_valid}, 32'h1);
`endif
        cycle(0, '0, 1);
        check_eq("rd_idle_req", {31'b0, mem_req}, 32'h0);
        cycle(0, '0, 1);
        check_eq("rd_next_addr", mem_addr, 32'h200);

        // Field split on ADD and ADDI encodings.
        apply_reset();
        for (int i = 0; i < 20 && pops < 3; i++) cycle(0, '0, 1);
        check_eq("add_pc", last_pop_pc, 32'h8);
        check_eq("add_opcode", {26'b0, last_pop_op}, 32'h00);
        check_eq("add_func", {26'b0, last_pop_fn}, 32'h20);
        for (int i = 0; i < 20 && pops < 4; i++) cycle(0, '0, 1);
        check_eq("addi_opcode", {26'b0, last_pop_op}, 32'h08);
        check_eq("addi_func", {26'b0, last_pop_fn}, 32'h05);

        // Asynchronous reset in the middle of a request.
        apply_reset();
        lat_mode = 4;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle(0, '0, 1);
            if (mem_req && !mem_ack && mem_addr == 32'h1C) found = 1;
        end
        check_eq("midreq_reach_0x1c", {31'b0, found}, 32'h1);
        apply_reset();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(0, '0, 1);
            if (mem_req) found = 1;
        end
        check_eq("post_rst_req", {31'b0, found}, 32'h1);
        check_eq("post_rst_addr", mem_addr, 32'h0);

        // Randomized traffic: variable latency, back-pressure, redirects.
        lat_mode = -1;
        apply_reset();
        salt = $urandom;
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            cycle($urandom_range(0, 30) == 0, rpc, $urandom_range(0, 3) != 0);
        end
        p0 = pops;
        repeat (40) cycle(0, '0, 1);
        check_eq("drain_progress", {31'b0, pops > p0 + 8}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Producer end of the control-unit decode interface. Fetches 32-bit MIPS instructions from instruction memory through a req/ack port and buffers them in a small prefetch FIFO. Presents each instruction with its PC, pre-split opcode[31:26] and func[5:0] fields, to the decode stage over a valid/ready handshake. Handles jump/branch redirects by flushing the FIFO and discarding in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
clk  in  1  single clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
mem_req  out  1  instruction read request, level.
mem_addr  out  32  word-aligned read address.
mem_ack  in  1  read complete; mem_rdata valid this cycle.
mem_rdata  in  32  instruction word.
redirect  in  1  flush and restart fetch at redirect_pc.
redirect_pc  in  32  new fetch PC; bits [1:0] ignored, forced to 0.
out_valid  out  1  head entry valid.
out_ready  in  1  decode accepts head.
out_inst  out  32  head instruction.
out_pc  out  32  head PC.
out_opcode  out  6  out_inst[31:26].
out_func  out  6  out_inst[5:0].

Behaviour:
- Reset, asynchronous: mem_req=0, mem_addr=RESET_PC, out_valid=0, FIFO empty, fetch_pc=RESET_PC, state=IDLE. Reset asserted mid-transaction abandons it; no response is expected afterwards.
- Memory handshake: a transaction completes on a cycle with mem_req && mem_ack. While mem_req=1, mem_addr is held stable. mem_ack with mem_req=0 is ignored. At most one request is outstanding.
- States:
  - IDLE: if (count + 0) < DEPTH and no redirect, assert mem_req with addr=fetch_pc, then go to REQ.
  - REQ: on ack, push {fetch_pc, mem_rdata} and set fetch_pc += 4, wrapping mod 2^32. Back-to-back: if space remains after the push (accounting for a simultaneous pop), stay in REQ with the new address the next cycle; otherwise go to IDLE.
  - DROP: keep mem_req and the old address until ack, discard the data, then go to IDLE.
- Redirect has priority over everything in the same cycle. It flushes the FIFO (out_valid=0 next cycle; a same-cycle pop is void) and sets fetch_pc=redirect_pc.
  - In REQ with no ack that cycle: go to DROP.
  - In REQ with ack that same cycle: discard the data and go to IDLE.
  - In IDLE: stay in IDLE; a request to redirect_pc issues the next cycle.
  - Redirect while in DROP: update fetch_pc only and remain in DROP.
- FIFO: pop on out_valid && out_ready. Push and pop in the same cycle are both allowed, with count unchanged. Pointers are log2(DEPTH) bits and wrap naturally. There is no push when full, guaranteed by the issue rule.
- Output latency: ack to out_valid is 1 cycle (registered FIFO head). out_* are stable while out_valid && !out_ready.
- Steady-state throughput with a 1-cycle memory is one instruction per cycle.

Optional Feature:
IFQ_BYPASS_EN.
- Defined: when the FIFO is empty, a non-redirect ack drives out_valid=1 combinationally in the same cycle, with out_inst=mem_rdata and out_pc=fetch_pc. If out_ready=1 the entry is consumed and not pushed; otherwise it is pushed normally.
- Undefined: latency is always 1 cycle through the FIFO, and out_* are purely registered.

Decomposition:
- Package ifq_pkg holds:
  - state enum {IDLE, REQ, DROP}
  - INST_BYTES=4
  - OPCODE_MSB=31, OPCODE_LSB=26, FUNC_MSB=5, FUNC_LSB=0
  - typedef ifq_entry_t {pc[31:0], inst[31:0]}
- One sub-module, ifq_fifo: a parameterised synchronous FIFO of ifq_entry_t with push, pop, flush, count, empty and full, using the same clk/rst_n.
- The FSM and PC logic stay in the top module.

Test Plan:
- Reset then 1-cycle-ack memory returning word=addr, out_ready=1 -> mem_addr 0,4,8,..., out_pc=0 with out_inst=0 two cycles after reset release, then one entry per cycle.
- out_ready=0 with DEPTH=4 -> exactly 4 acks accepted, mem_req deasserts, count=4; raise out_ready -> entries pop in order 0,4,8,C and fetch resumes at 0x10.
- Redirect to 0x400 while a request to 0x10 is pending (ack 3 cycles later) -> FIFO flushed, mem_addr held at 0x10 until ack, data dropped, next request at 0x400, first out_pc=0x400.
- Redirect, ack and pop in the same cycle -> acked data discarded, no pop counted, next mem_addr=redirect_pc.
- Instruction 0x0000_0020 (ADD) at PC 0x8 -> out_opcode=6'h00, out_func=6'h20; 0x2008_0005 (ADDI) -> out_opcode=6'h08, out_func=6'h05.
- rst_n asserted mid-REQ with fetch_pc=0x1C -> outputs return to reset values immediately, and after release the first mem_addr=RESET_PC.
